irq_request_arbiter: RTL
========================

// Module: irq_request_arbiter
// PURPOSE
//  Front end for the 8-input lowest-index-first priority_encoder. Captures raw request lines as
//  sticky pending bits, applies a per-line mask and selects the winning line with the encoder.
//  Presents the winning line's code on a valid/ready interface.
//  Clears only the accepted line's pending bit. Sits between peripheral request wires and the
//  consumer (CPU/DMA sequencer) that services one request at a time.
// PARAMETERS
//  N_REQ        8   number of request lines, legal range 2..8
//  CODE_W       3   width of irq_code; fixed at 3 to match priority_encoder
//  EDGE_DETECT  1   1: a request is captured on the rising edge of req; 0: captured while req is high (level)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  req        in   N_REQ   raw request lines, already synchronous to clk
//  mask       in   N_REQ   1 = line disabled for selection; capture is unaffected
//  irq_valid  out  1       irq_code holds a pending, selected request
//  irq_code   out  CODE_W  index of the presented line; 0 when irq_valid=0
//  irq_ready  in   1       consumer accepts; transfer occurs when irq_valid & irq_ready
//  pending    out  N_REQ   sticky pending register, for status readback
//  dropped    out  1       1-cycle pulse: a capture hit a line that was already pending
// BEHAVIOUR
//  Reset:
//   - irq_valid=0, irq_code=0, pending=0, dropped=0, FSM=IDLE.
//   - req_q is loaded with req during rst, so a line held high through reset does not produce an edge.
//  Capture:
//   - cap = EDGE_DETECT ? (req & ~req_q) : req. req_q is updated to req every cycle.
//   - pending <= (pending & ~clr) | cap. clr is a one-hot of irq_code, asserted only on a transfer.
//   - Same-cycle capture and clear on one bit: capture wins, the bit stays set, and dropped is not asserted.
//   - dropped <= |(cap & pending & ~clr).
//  Select:
//   - eligible = pending & ~mask, zero-extended to 8 bits into priority_encoder.
//   - The encoder result is used only when |eligible is true. Its output for an all-zero input is never sampled.
//  FSM, 2 states:
//   - IDLE: irq_valid=0. If |eligible, register the encoder code into irq_code, set irq_valid and go to PRESENT.
//   - PRESENT: irq_valid=1 and irq_code held stable, even if a higher-priority line arrives or the presented
//     line becomes masked; valid is never withdrawn. On irq_ready, clear that pending bit, drop irq_valid
//     and go to IDLE.
//  Latency and throughput:
//   - Latency: req rises before clock edge E0, pending is set at E0, irq_valid is high after E1.
//     That is 2 cycles from sampling.
//   - A transfer is followed by at least one cycle with irq_valid=0 (the IDLE re-arbitration cycle).
//     Maximum throughput is therefore one grant every 2 cycles.
//  Other rules:
//   - Unmasking a line that is already pending: irq_valid is high 1 cycle after mask falls (when IDLE).
//   - Reset mid-operation wins over everything: the next cycle shows irq_valid=0 and pending=0,
//     and an in-flight grant is discarded.
//   - Bits of N_REQ..7 at the encoder input are tied to 0; irq_code < N_REQ always.
// STRUCTURE
//  Shared header/package irq_pkg:
//   - IRQ_N_REQ_MAX=8, IRQ_CODE_W=3
//   - FSM localparams S_IDLE=1'b0, S_PRESENT=1'b1
//  Sub-module:
//   - priority_encoder, one instance, combinational on eligible.
//   - All state (req_q, pending, FSM, irq_code, dropped) lives in this module. No other sub-modules.
// TESTING
//  T1 Reset: rst=1 with req=8'h01 held, then release -> irq_valid stays 0 for 10 cycles; pending=8'h00.
//  T2 Two lines: one-cycle req=8'h24 pulse, irq_ready=1 ->
//     - valid after 2 cycles with code=2; pending goes to 8'h20.
//     - valid low 1 cycle, then valid with code=5; pending goes to 8'h00.
//  T3 Held code: irq_ready=0 while code 5 is presented, pulse req bit0 ->
//     - irq_code stays 5 and pending=8'h21.
//     - Raise ready: code 5 accepted, then code 0 presented.
//  T4 Masking: mask=8'h01, pulse req bit0 -> pending=8'h01 and irq_valid=0 for 20 cycles.
//     Clear mask -> valid one cycle later with code=0.
//  T5 Dropped/clear race:
//     - Second rising edge on bit3 while it is pending -> dropped pulses 1 cycle and pending[3] stays 1.
//     - Rising edge on bit3 in the same cycle as its acceptance -> no dropped pulse; code 3 re-presented.
//  T6 Reset mid-grant: assert rst while irq_valid=1 -> next cycle irq_valid=0, irq_code=0, pending=0.
//     Also run T2 with EDGE_DETECT=0 and req held -> code 2 re-captured after each accept.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and FSM state encoding for the interrupt request arbiter.
package irq_pkg;

    localparam int IRQ_N_REQ_MAX = 8;
    localparam int IRQ_CODE_W    = 3;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } irq_state_e;

endpackage

// File: rtl/irq_request_arbiter_if.sv
// Valid/ready channel that carries the selected request code to its consumer.
interface irq_request_arbiter_if
    import irq_pkg::*;
#(
    parameter int CODE_W = IRQ_CODE_W
);

    logic              irq_valid;
    logic [CODE_W-1:0] irq_code;
    logic              irq_ready;

    modport master (output irq_valid, output irq_code, input  irq_ready);
    modport slave  (input  irq_valid, input  irq_code, output irq_ready);

endinterface

// File: rtl/priority_encoder.sv
// 8-input priority encoder: the lowest set index wins. The result for an
// all-zero input is a don't-care and is never used by the arbiter.
module priority_encoder
    import irq_pkg::*;
(
    input  logic [IRQ_N_REQ_MAX-1:0] in_i,
    output logic [IRQ_CODE_W-1:0]    code_o
);

    // Scan from the top down so that the lowest set bit is the last write.
    always_comb begin
        // NOTE: default assignment first so every path drives code_o and no latch is inferred.
        code_o = '0;
        for (int i = IRQ_N_REQ_MAX - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                code_o = IRQ_CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_request_arbiter.sv
// Interrupt request arbiter: captures request lines into sticky pending bits,
// masks them, picks the lowest eligible line and presents it on a valid/ready
// channel. Only the accepted line's pending bit is cleared.
module irq_request_arbiter
    import irq_pkg::*;
#(
    parameter int N_REQ       = 8,
    parameter int CODE_W      = IRQ_CODE_W,
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      mask,
    irq_request_arbiter_if.master irq_bus,
    output logic [N_REQ-1:0]      pending,
    output logic                  dropped
);

    logic [N_REQ-1:0]         req_q;
    logic [N_REQ-1:0]         pending_q;
    logic [N_REQ-1:0]         pending_d;
    logic [N_REQ-1:0]         cap;
    logic [N_REQ-1:0]         clr;
    logic                     dropped_q;
    logic                     dropped_d;
    logic [IRQ_N_REQ_MAX-1:0] eligible;
    logic [IRQ_CODE_W-1:0]    enc_code;
    irq_state_e               state_q;
    logic                     valid_q;
    logic [CODE_W-1:0]        code_q;
    logic                     transfer;

    assign transfer = (state_q == S_PRESENT) && irq_bus.irq_ready;

    // Capture, clear-on-accept and drop detection; capture beats a same-cycle clear.
    always_comb begin
        cap       = EDGE_DETECT ? (req & ~req_q) : req;
        clr       = transfer ? (N_REQ'(1) << code_q) : '0;
        pending_d = (pending_q & ~clr) | cap;
        dropped_d = |(cap & pending_q & ~clr);
        // Unused encoder inputs above N_REQ are zero-filled by the cast.
        eligible  = IRQ_N_REQ_MAX'(pending_q & ~mask);
    end

    priority_encoder u_enc (
        .in_i   (eligible),
        .code_o (enc_code)
    );

    // Request history, pending register and drop pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            req_q     <= req;  // a line held high through reset must not look like an edge
            pending_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            req_q     <= req;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    // Presentation FSM: latch a winner in IDLE, hold it in PRESENT until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|eligible) begin
                        state_q <= S_PRESENT;
                        valid_q <= 1'b1;
                        code_q  <= CODE_W'(enc_code);
                    end
                end
                S_PRESENT: begin
                    if (irq_bus.irq_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        code_q  <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    code_q  <= '0;
                end
            endcase
        end
    end

    assign irq_bus.irq_valid = valid_q;
    assign irq_bus.irq_code  = code_q;
    assign pending           = pending_q;
    assign dropped           = dropped_q;

endmodule
